// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Purpose:
//   Final pipeline stage of the core. Selects the value that is written back to
//   the register file (ALU result, PC+4 or an aligned load), and holds the
//   upstream pipeline while a load waits for its data-memory response.
//
//   FSM:
//     IDLE      - nothing to write this cycle.
//     WAIT_LOAD - a load was accepted; waiting for dmem_rvalid. wb_stall=1.
//     WRITE     - data_wb/rd carry a fresh result; reg_wen may be asserted.
//
// Optional feature:
//   WB_PERF_COUNTER_EN - when defined, adds perf_wb_count and perf_stall_count
//   (32-bit, wrap-around) counting reg_wen and wb_stall cycles respectively.
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst_n           in   asynchronous active-low reset
//   mem_valid       in   MEM-stage instruction valid
//   mem_reg_wen     in   instruction writes rd
//   mem_rd          in   [4:0] destination register
//   mem_wb_sel      in   [1:0] 00 ALU, 01 load, 10 PC+4, 11 ALU
//   mem_alu_result  in   [DATA_LENGTH-1:0] ALU result
//   mem_pc4         in   [DATA_LENGTH-1:0] PC+4
//   mem_load_type   in   [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   mem_addr_lo     in   [1:0] load address bits [1:0]
//   dmem_rvalid     in   data-memory read response valid
//   dmem_rdata      in   [DATA_LENGTH-1:0] raw read word
//   data_wb         out  [DATA_LENGTH-1:0] register-file write data
//   rd              out  [4:0] register-file write address
//   reg_wen         out  register-file write enable
//   wb_stall        out  upstream hold request
//   perf_wb_count   out  [31:0] (WB_PERF_COUNTER_EN only)
//   perf_stall_count out [31:0] (WB_PERF_COUNTER_EN only)
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_valid,
  input  logic                   mem_reg_wen,
  input  logic [4:0]             mem_rd,
  input  logic [1:0]             mem_wb_sel,
  input  logic [DATA_LENGTH-1:0] mem_alu_result,
  input  logic [DATA_LENGTH-1:0] mem_pc4,
  input  logic [2:0]             mem_load_type,
  input  logic [1:0]             mem_addr_lo,
  input  logic                   dmem_rvalid,
  input  logic [DATA_LENGTH-1:0] dmem_rdata,
  output logic [DATA_LENGTH-1:0] data_wb,
  output logic [4:0]             rd,
  output logic                   reg_wen,
  output logic                   wb_stall
`ifdef WB_PERF_COUNTER_EN
  ,
  output logic [31:0]            perf_wb_count,
  output logic [31:0]            perf_stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WAIT_LOAD = 2'b01,
    S_WRITE     = 2'b10
  } state_t;

  // Extracts and extends the addressed byte/halfword of a load response.
  // Undefined funct3 codes fall back to a full-word load.
  function automatic logic [DATA_LENGTH-1:0] align_load(
    input logic [DATA_LENGTH-1:0] word,
    input logic [2:0]             ltype,
    input logic [1:0]             addr_lo
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = word[{addr_lo[1], 4'b0000} +: 16];
    case (ltype)
      3'b000:  align_load = {{(DATA_LENGTH-8){b[7]}}, b};
      3'b001:  align_load = {{(DATA_LENGTH-16){h[15]}}, h};
      3'b100:  align_load = {{(DATA_LENGTH-8){1'b0}}, b};
      3'b101:  align_load = {{(DATA_LENGTH-16){1'b0}}, h};
      default: align_load = word;
    endcase
  endfunction

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_accept_direct;
  logic                   w_accept_load;
  logic                   w_load_done;
  logic [DATA_LENGTH-1:0] w_sel_data;

  logic [DATA_LENGTH-1:0] r_data_wb;
  logic [4:0]             r_rd;
  logic                   r_wen;

  // Load context is parked here so rd/data_wb keep showing the previous
  // write until the load data actually arrives.
  logic [4:0]             r_pend_rd;
  logic                   r_pend_wen;
  logic [2:0]             r_pend_type;
  logic [1:0]             r_pend_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_accept_direct = 1'b0;
    w_accept_load   = 1'b0;
    w_load_done     = 1'b0;
    case (r_state)
      S_WAIT_LOAD: begin
        // mem_valid is deliberately ignored: upstream is holding the load.
        if (dmem_rvalid) begin
          w_next      = S_WRITE;
          w_load_done = 1'b1;
        end
      end
      default: begin
        // IDLE, WRITE and the unused encoding all behave alike.
        if (mem_valid) begin
          if (mem_wb_sel == 2'b01) begin
            w_next        = S_WAIT_LOAD;
            w_accept_load = 1'b1;
          end else begin
            w_next          = S_WRITE;
            w_accept_direct = 1'b1;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_sel_data = mem_alu_result;
    if (mem_wb_sel == 2'b10) begin
      w_sel_data = mem_pc4;
    end
  end

  // Writeback result registers: updated only when entering WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_wb <= '0;
      r_rd      <= 5'd0;
      r_wen     <= 1'b0;
    end else if (w_accept_direct) begin
      r_data_wb <= w_sel_data;
      r_rd      <= mem_rd;
      r_wen     <= mem_reg_wen;
    end else if (w_load_done) begin
      r_data_wb <= align_load(dmem_rdata, r_pend_type, r_pend_addr);
      r_rd      <= r_pend_rd;
      r_wen     <= r_pend_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_rd   <= 5'd0;
      r_pend_wen  <= 1'b0;
      r_pend_type <= 3'd0;
      r_pend_addr <= 2'd0;
    end else if (w_accept_load) begin
      r_pend_rd   <= mem_rd;
      r_pend_wen  <= mem_reg_wen;
      r_pend_type <= mem_load_type;
      r_pend_addr <= mem_addr_lo;
    end
  end

  assign data_wb  = r_data_wb;
  assign rd       = r_rd;
  // Writes to x0 are suppressed here rather than in the register file.
  assign reg_wen  = (r_state == S_WRITE) && r_wen && (r_rd != 5'd0);
  assign wb_stall = (r_state == S_WAIT_LOAD);

`ifdef WB_PERF_COUNTER_EN
  logic [31:0] r_perf_wb;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_wb    <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (reg_wen) begin
        r_perf_wb <= r_perf_wb + 32'd1;
      end
      if (wb_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_wb_count    = r_perf_wb;
  assign perf_stall_count = r_perf_stall;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int DL = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_valid;
  logic          mem_reg_wen;
  logic [4:0]    mem_rd;
  logic [1:0]    mem_wb_sel;
  logic [DL-1:0] mem_alu_result;
  logic [DL-1:0] mem_pc4;
  logic [2:0]    mem_load_type;
  logic [1:0]    mem_addr_lo;
  logic          dmem_rvalid;
  logic [DL-1:0] dmem_rdata;
  logic [DL-1:0] data_wb;
  logic [4:0]    rd;
  logic          reg_wen;
  logic          wb_stall;
`ifdef WB_PERF_COUNTER_EN
  logic [31:0]   perf_wb_count;
  logic [31:0]   perf_stall_count;
`endif

  always #5 clk = ~clk;

  writeback_unit #(.DATA_LENGTH(DL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_reg_wen    (mem_reg_wen),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_pc4        (mem_pc4),
    .mem_load_type  (mem_load_type),
    .mem_addr_lo    (mem_addr_lo),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .data_wb        (data_wb),
    .rd             (rd),
    .reg_wen        (reg_wen),
    .wb_stall       (wb_stall)
`ifdef WB_PERF_COUNTER_EN
    ,
    .perf_wb_count    (perf_wb_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_rd;
  logic [31:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input logic ew, input logic es);
    chk({tag, ".reg_wen"},  {31'd0, reg_wen},  {31'd0, ew});
    chk({tag, ".rd"},       {27'd0, rd},       exp_rd);
    chk({tag, ".data_wb"},  data_wb,           exp_data);
    chk({tag, ".wb_stall"}, {31'd0, wb_stall}, {31'd0, es});
  endtask

  // Reference load alignment from arithmetic on the word value.
  function automatic logic [31:0] load_ref(input logic [31:0] w, input int t, input int a);
    int unsigned v;
    case (t)
      0: begin v = (w >> (8 * a)) % 256;         if (v >= 128)   v = v - 256;   end
      4: begin v = (w >> (8 * a)) % 256;                                          end
      1: begin v = (w >> (16 * (a / 2))) % 65536; if (v >= 32768) v = v - 65536; end
      5: begin v = (w >> (16 * (a / 2))) % 65536;                                 end
      default: v = w;
    endcase
    return v;
  endfunction

  // One cycle with no valid instruction; stray responses must be ignored.
  task automatic drive_idle(input string tag);
    mem_valid   = 1'b0;
    mem_wb_sel  = 2'($urandom_range(0, 3));
    mem_rd      = 5'($urandom);
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    @(posedge clk);
    @(negedge clk);
    check_out(tag, 1'b0, 1'b0);
    dmem_rvalid = 1'b0;
  endtask

  task automatic issue_direct(input logic [1:0] sel, input logic [4:0] r, input logic w,
                              input logic [31:0] alu, input logic [31:0] pc4, input string tag);
    mem_valid      = 1'b1;
    mem_wb_sel     = sel;
    mem_rd         = r;
    mem_reg_wen    = w;
    mem_alu_result = alu;
    mem_pc4        = pc4;
    mem_load_type  = 3'($urandom);
    mem_addr_lo    = 2'($urandom);
    dmem_rvalid    = 1'($urandom_range(0, 1));
    dmem_rdata     = $urandom;
    @(posedge clk);
    @(negedge clk);
    exp_rd   = {27'd0, r};
    exp_data = (sel == 2'b10) ? pc4 : alu;
    check_out(tag, w && (r != 5'd0), 1'b0);
    mem_valid   = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // Load accepted, response arrives on the nstall-th stall cycle.
  task automatic issue_load(input logic [2:0] t, input logic [1:0] a, input logic [4:0] r,
                            input logic w, input logic [31:0] word, input int nstall,
                            input string tag);
    mem_valid      = 1'b1;
    mem_wb_sel     = 2'b01;
    mem_rd         = r;
    mem_reg_wen    = w;
    mem_load_type  = t;
    mem_addr_lo    = a;
    mem_alu_result = $urandom;
    dmem_rvalid    = 1'b0;
    @(posedge clk);
    for (int s = 1; s <= nstall; s++) begin
      @(negedge clk);
      check_out({tag, ".wait"}, 1'b0, 1'b1);
      if (s == nstall) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
      end else begin
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
      end
      @(posedge clk);
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    mem_valid   = 1'b0;
    exp_rd   = {27'd0, r};
    exp_data = load_ref(word, int'(t), int'(a));
    check_out(tag, w && (r != 5'd0), 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_valid      = 1'b0;
    mem_reg_wen    = 1'b0;
    mem_rd         = 5'd0;
    mem_wb_sel     = 2'b00;
    mem_alu_result = '0;
    mem_pc4        = '0;
    mem_load_type  = 3'd0;
    mem_addr_lo    = 2'd0;
    dmem_rvalid    = 1'b0;
    dmem_rdata     = '0;
    exp_rd         = 32'd0;
    exp_data       = 32'd0;

    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 1'b0);
    rst_n = 1'b1;

    // ALU write
    issue_direct(2'b00, 5'd5, 1'b1, 32'h12345678, 32'h0000_0AAA, "alu_rd5");
    chk("alu_rd5.const", data_wb, 32'h12345678);

    // x0 suppression with PC+4 select
    issue_direct(2'b10, 5'd0, 1'b1, 32'hDEAD_0000, 32'h0000_0104, "x0_pc4");
    chk("x0_pc4.const", data_wb, 32'h0000_0104);

    // Load alignment
    issue_load(3'b000, 2'd2, 5'd7, 1'b1, 32'h00F30000, 3, "lb");
    chk("lb.const", data_wb, 32'hFFFFFFF3);
    issue_load(3'b101, 2'd2, 5'd7, 1'b1, 32'h8001ABCD, 3, "lhu");
    chk("lhu.const", data_wb, 32'h00008001);
    drive_idle("idle0");

    // Back-to-back: two ALU writes then a load
    issue_direct(2'b00, 5'd1, 1'b1, 32'h11, 32'h0, "b2b_rd1");
    issue_direct(2'b11, 5'd2, 1'b1, 32'h22, 32'h0, "b2b_rd2");
    issue_load(3'b010, 2'd0, 5'd3, 1'b1, 32'hCAFEF00D, 2, "b2b_ld");
    drive_idle("idle1");

    // Reset while waiting for a load
    mem_valid     = 1'b1;
    mem_wb_sel    = 2'b01;
    mem_rd        = 5'd9;
    mem_reg_wen   = 1'b1;
    mem_load_type = 3'b010;
    mem_addr_lo   = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check_out("rstmid.wait", 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_rd   = 32'd0;
    exp_data = 32'd0;
    check_out("rstmid.async", 1'b0, 1'b0);
    @(negedge clk);
    rst_n       = 1'b1;
    mem_valid   = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_out("rstmid.after", 1'b0, 1'b0);
    end
    dmem_rvalid = 1'b0;

    // Randomized mix against the reference model
    for (int i = 0; i < 80; i++) begin
      int          op;
      int          pick;
      logic [1:0]  sel;
      logic [4:0]  r;
      op   = $urandom_range(0, 3);
      r    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (op == 0) begin
        drive_idle("rnd_idle");
      end else if (op == 3) begin
        issue_load(3'($urandom_range(0, 7)), 2'($urandom), r, 1'($urandom_range(0, 1)),
                   $urandom, $urandom_range(1, 4), "rnd_load");
      end else begin
        pick = $urandom_range(0, 2);
        sel  = (pick == 0) ? 2'b00 : ((pick == 1) ? 2'b10 : 2'b11);
        issue_direct(sel, r, 1'($urandom_range(0, 1)), $urandom, $urandom, "rnd_direct");
      end
    end

`ifdef WB_PERF_COUNTER_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_rd   = 32'd0;
    exp_data = 32'd0;
    chk("perf.rst_wb", perf_wb_count, 32'd0);
    chk("perf.rst_stall", perf_stall_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_direct(2'b00, 5'd4, 1'b1, 32'h44, 32'h0, "perf_a1");
    issue_direct(2'b00, 5'd6, 1'b1, 32'h66, 32'h0, "perf_a2");
    issue_load(3'b010, 2'd0, 5'd8, 1'b1, 32'h88, 3, "perf_ld");
    drive_idle("perf_idle");
    chk("perf.wb_count", perf_wb_count, 32'd3);
    chk("perf.stall_count", perf_stall_count, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
